// File: rtl/tlul_dbus_demux.sv
// TL-UL 1:2 data-bus demux: routes core requests to data memory, peripherals or an internal error responder.
// Optional macro DBUS_ALIGN_CHECK_EN: misaligned or mask-inconsistent requests are sent to the error responder.
package tlul_dbus_demux_pkg;
  localparam int unsigned TL_AW = 32;
  localparam int unsigned TL_DW = 32;
  localparam int unsigned TL_MW = 4;
  localparam int unsigned TL_SW = 8;

  localparam logic [2:0] TL_PUT_FULL    = 3'h0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'h1;
  localparam logic [2:0] TL_GET         = 3'h4;
  localparam logic [2:0] TL_ACK         = 3'h0;
  localparam logic [2:0] TL_ACK_DATA    = 3'h1;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [TL_SW-1:0] a_source;
    logic [TL_AW-1:0] a_address;
    logic [TL_MW-1:0] a_mask;
    logic [TL_DW-1:0] a_data;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [1:0]       d_size;
    logic [TL_SW-1:0] d_source;
    logic [TL_DW-1:0] d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;
endpackage

module tlul_dbus_demux
  import tlul_dbus_demux_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] DMEM_BASE       = 32'h0001_0000,
  parameter logic [31:0] DMEM_MASK       = 32'h0000_FFFF,
  parameter logic [31:0] PERIPH_BASE     = 32'h4000_0000,
  parameter logic [31:0] PERIPH_MASK     = 32'h0FFF_FFFF
) (
  input  logic    clock,
  input  logic    reset,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o,
  output tl_h2d_t tl_dmem_o,
  input  tl_d2h_t tl_dmem_i,
  output tl_h2d_t tl_periph_o,
  input  tl_d2h_t tl_periph_i
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    TGT_DMEM   = 2'd0,
    TGT_PERIPH = 2'd1,
    TGT_ERR    = 2'd2
  } tgt_e;

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  tgt_e             out_tgt_q, out_tgt_d;
  logic             err_vld_q, err_vld_d;
  logic [TL_SW-1:0] err_source_q, err_source_d;
  logic [1:0]       err_size_q, err_size_d;
  logic [2:0]       err_opcode_q, err_opcode_d;

  logic hit_dmem, hit_periph;
  tgt_e req_tgt;
  logic can_issue, sel_a_ready, a_ready_c, a_acc;
  logic rsp_active, h_d_valid, d_acc;

`ifdef DBUS_ALIGN_CHECK_EN
  logic [TL_MW-1:0] exp_mask;
  logic             align_err;

  // Natural alignment plus a byte mask that covers exactly the addressed bytes.
  always_comb begin
    exp_mask  = '0;
    align_err = 1'b0;
    case (tl_h_i.a_size)
      2'd0: exp_mask = TL_MW'(4'b0001 << tl_h_i.a_address[1:0]);
      2'd1: begin
        exp_mask  = TL_MW'(4'b0011 << tl_h_i.a_address[1:0]);
        align_err = tl_h_i.a_address[0];
      end
      2'd2: begin
        exp_mask  = 4'hF;
        align_err = |tl_h_i.a_address[1:0];
      end
      default: align_err = 1'b1;
    endcase
    if (tl_h_i.a_mask != exp_mask) align_err = 1'b1;
  end
`endif

  // Address decode; data memory wins on overlap.
  always_comb begin
    hit_dmem   = (tl_h_i.a_address & ~DMEM_MASK) == DMEM_BASE;
    hit_periph = (tl_h_i.a_address & ~PERIPH_MASK) == PERIPH_BASE;
    if (hit_dmem)        req_tgt = TGT_DMEM;
    else if (hit_periph) req_tgt = TGT_PERIPH;
    else                 req_tgt = TGT_ERR;
`ifdef DBUS_ALIGN_CHECK_EN
    if (align_err) req_tgt = TGT_ERR;
`endif
  end

  // Issue gating: capacity, single target in flight, one-entry error responder.
  always_comb begin
    can_issue = (out_cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                ((out_cnt_q == '0) || (req_tgt == out_tgt_q));
    if ((req_tgt == TGT_ERR) && err_vld_q) can_issue = 1'b0;
    if (reset) can_issue = 1'b0;

    case (req_tgt)
      TGT_DMEM:   sel_a_ready = tl_dmem_i.a_ready;
      TGT_PERIPH: sel_a_ready = tl_periph_i.a_ready;
      default:    sel_a_ready = !err_vld_q;
    endcase
    a_ready_c  = can_issue && sel_a_ready;
    a_acc      = tl_h_i.a_valid && a_ready_c;
    rsp_active = (out_cnt_q != '0) && !reset;
  end

  // A-channel pass-through and D-channel steering.
  always_comb begin
    tl_dmem_o           = tl_h_i;
    tl_dmem_o.a_valid   = tl_h_i.a_valid && can_issue && (req_tgt == TGT_DMEM);
    tl_dmem_o.d_ready   = tl_h_i.d_ready && rsp_active && (out_tgt_q == TGT_DMEM);
    tl_periph_o         = tl_h_i;
    tl_periph_o.a_valid = tl_h_i.a_valid && can_issue && (req_tgt == TGT_PERIPH);
    tl_periph_o.d_ready = tl_h_i.d_ready && rsp_active && (out_tgt_q == TGT_PERIPH);

    tl_h_o = '0;
    case (out_tgt_q)
      TGT_DMEM:   tl_h_o = tl_dmem_i;
      TGT_PERIPH: tl_h_o = tl_periph_i;
      default: begin
        tl_h_o.d_valid  = err_vld_q;
        tl_h_o.d_opcode = (err_opcode_q == TL_GET) ? TL_ACK_DATA : TL_ACK;
        tl_h_o.d_param  = 3'h0;
        tl_h_o.d_size   = err_size_q;
        tl_h_o.d_source = err_source_q;
        tl_h_o.d_data   = 32'hFFFF_FFFF;
        tl_h_o.d_error  = 1'b1;
      end
    endcase
    h_d_valid      = tl_h_o.d_valid && rsp_active;
    tl_h_o.d_valid = h_d_valid;
    tl_h_o.a_ready = a_ready_c;
    d_acc          = h_d_valid && tl_h_i.d_ready;
  end

  // Outstanding tracking and error responder capture/release.
  always_comb begin
    out_cnt_d    = out_cnt_q;
    out_tgt_d    = out_tgt_q;
    err_vld_d    = err_vld_q;
    err_source_d = err_source_q;
    err_size_d   = err_size_q;
    err_opcode_d = err_opcode_q;

    if (a_acc && !d_acc)      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!a_acc && d_acc) out_cnt_d = out_cnt_q - CNT_W'(1);

    if (a_acc) out_tgt_d = req_tgt;

    if (a_acc && (req_tgt == TGT_ERR)) begin
      err_vld_d    = 1'b1;
      err_source_d = tl_h_i.a_source;
      err_size_d   = tl_h_i.a_size;
      err_opcode_d = tl_h_i.a_opcode;
    end else if (d_acc && (out_tgt_q == TGT_ERR)) begin
      err_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_cnt_q    <= '0;
      out_tgt_q    <= TGT_DMEM;
      err_vld_q    <= 1'b0;
      err_source_q <= '0;
      err_size_q   <= '0;
      err_opcode_q <= '0;
    end else begin
      out_cnt_q    <= out_cnt_d;
      out_tgt_q    <= out_tgt_d;
      err_vld_q    <= err_vld_d;
      err_source_q <= err_source_d;
      err_size_q   <= err_size_d;
      err_opcode_q <= err_opcode_d;
    end
  end

  // A slave answering when it owns nothing in flight breaks the protocol; it is dropped above.
  logic stray_rsp;
  assign stray_rsp = (tl_dmem_i.d_valid && ((out_cnt_q == '0) || (out_tgt_q != TGT_DMEM))) ||
                     (tl_periph_i.d_valid && ((out_cnt_q == '0) || (out_tgt_q != TGT_PERIPH)));

  stray_rsp_a: assert property (@(posedge clock) disable iff (reset) !stray_rsp);

endmodule
